dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data width of both ports and the memory.
REQ-002 The block SHALL have parameter ADDR_W, default 32: address width of both ports and the memory.
REQ-003 The block SHALL have parameter MAX_STARVE, default 4, legal 1..15: denied cycles after which port 1 wins.
REQ-004 Port clk  in  1: single clock, all state on its rising edge.
REQ-005 Port resetn  in  1: asynchronous, active-low reset.
REQ-006 Ports req0/req1  in  1: request from port 0 (CPU) and port 1 (I/O loader).
REQ-007 Ports we0/we1  in  1: 1 = write, 0 = read.
REQ-008 Ports addr0/addr1  in  ADDR_W: request address.
REQ-009 Ports wdata0/wdata1  in  DATA_W: write data.
REQ-010 Ports gnt0/gnt1  out  1: combinational grant; transfer accepted at the edge where req&gnt.
REQ-011 Ports rvalid0/rvalid1  out  1: registered read-data-valid strobe.
REQ-012 Ports rdata0/rdata1  out  DATA_W: mem_rdata when own rvalid = 1, else 0.
REQ-013 Port mem_en  out  1: registered memory command strobe.
REQ-014 Port mem_we  out  1: registered memory write enable.
REQ-015 Port mem_addr  out  ADDR_W: registered memory address.
REQ-016 Port mem_wdata  out  DATA_W: registered memory write data.
REQ-017 Port mem_rdata  in  DATA_W: synchronous RAM read data, valid 1 cycle after mem_en.
REQ-018 Port starve_cnt  out  4: current port-1 starvation count.

Function
REQ-019 Grant policy: port 0 has fixed priority; port 1 wins when req0=0 or starve_cnt==MAX_STARVE.
REQ-020 At most one of gnt0/gnt1 SHALL be 1 in any cycle; gntX=0 whenever reqX=0.
REQ-021 starve_cnt: +1 on each edge with req1=1 and gnt1=0; cleared on an edge with req1&gnt1; it never exceeds MAX_STARVE.
REQ-022 If req1 drops before being granted, starve_cnt SHALL clear on the next edge.
REQ-023 Accepted transfer at edge t: in cycle t+1, mem_en=1 and mem_we/addr/wdata SHALL equal the winner's inputs sampled at t; otherwise mem_en=0 and mem_we=0.
REQ-024 For an accepted read at edge t, rvalidX=1 for exactly cycle t+2 for the winner X; writes SHALL produce no rvalid.
REQ-025 Throughput: one transfer per cycle; back-to-back grants to the same or alternating ports SHALL be supported with no bubble.
REQ-026 A requester SHALL hold req/we/addr/wdata stable until granted; the arbiter does not latch ungranted requests.
REQ-027 Read-after-write to the same address on consecutive cycles SHALL rely on RAM write-first behaviour; the arbiter adds no forwarding.

Reset
REQ-028 With resetn=0: mem_en, mem_we, rvalid0, rvalid1 = 0; mem_addr, mem_wdata = 0; starve_cnt = 0.
REQ-029 Reset asserted mid-transfer SHALL cancel the in-flight command and any pending rvalid; no rvalid follows deassertion.
REQ-030 gnt0/gnt1 SHALL be 0 while resetn=0.

Configuration
REQ-031 The macro DMEM_ARB_STATS_EN, when defined, SHALL add outputs gnt_cnt0 and gnt_cnt1 (16 bits each): saturating at 16'hFFFF, +1 per accepted transfer on that port, reset to 0.
REQ-032 Without DMEM_ARB_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-033 Port-0 only: read addr 0x10, RAM holds 0xCAFE -> gnt0 same cycle, mem_en cycle+1, rvalid0=1 with rdata0=0xCAFE cycle+2, rvalid1=0.
REQ-034 Port-1 write: addr 0x20, data 0x5A5A, req0=0 -> gnt1, mem_we=1, mem_addr=0x20 next cycle; no rvalid.
REQ-035 Starvation: req0, req1 held high, MAX_STARVE=4 -> gnt0 for 4 cycles, gnt1 in the 5th, starve_cnt back to 0, then gnt0 again.
REQ-036 Alternating back-to-back reads (port 0, port 1, port 0) -> mem_en high 3 consecutive cycles; rvalid0, rvalid1, rvalid0 on 3 consecutive cycles with correct data.
REQ-037 resetn pulsed low one cycle after a granted read -> no rvalid; mem_en=0; starve_cnt=0.
REQ-038 With DMEM_ARB_STATS_EN: 70000 port-0 grants -> gnt_cnt0=16'hFFFF, gnt_cnt1 unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (CPU) has fixed priority, and port 1 (I/O loader) wins after MAX_STARVE denied cycles.
// Defining DMEM_ARB_STATS_EN adds the saturating per-port grant counters gnt_cnt0 and gnt_cnt1.
module dmem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int MAX_STARVE = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        starve_cnt
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
`endif
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_STARVE);

   logic starve_hit;
   logic accept;
   logic sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic rd_pend0;
   logic rd_pend1;

   // Port 1 only overrides port 0 once it has waited MAX_STARVE cycles.
   always_comb begin
      starve_hit = (starve_cnt == MAX_CNT);
      gnt1       = resetn & req1 & (~req0 | starve_hit);
      gnt0       = resetn & req0 & ~gnt1;
      accept     = gnt0 | gnt1;
      sel_we     = gnt1 ? we1    : we0;
      sel_addr   = gnt1 ? addr1  : addr0;
      sel_wdata  = gnt1 ? wdata1 : wdata0;
   end

   // A request that is withdrawn before its grant loses its accumulated starvation credit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (req1 && !gnt1) begin
         starve_cnt <= starve_cnt + 4'd1;
      end else begin
         starve_cnt <= '0;
      end
   end

   // Address and data hold their last value between commands; only en/we signal activity.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= accept;
         mem_we <= accept & sel_we;
         if (accept) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
      end
   end

   // The read owner travels alongside the command, so rvalid lines up with the RAM's one-cycle latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_pend0 <= 1'b0;
         rd_pend1 <= 1'b0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
      end else begin
         rd_pend0 <= gnt0 & ~we0;
         rd_pend1 <= gnt1 & ~we1;
         rvalid0  <= rd_pend0;
         rvalid1  <= rd_pend1;
      end
   end

   assign rdata0 = rvalid0 ? mem_rdata : '0;
   assign rdata1 = rvalid1 ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else begin
         if (gnt0 && gnt_cnt0 != 16'hFFFF) begin
            gnt_cnt0 <= gnt_cnt0 + 16'd1;
         end
         if (gnt1 && gnt_cnt1 != 16'hFFFF) begin
            gnt_cnt1 <= gnt_cnt1 + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes the expected memory commands and read returns into queues, and a negedge monitor checks them.
// Build with DMEM_ARB_STATS_EN defined to also exercise the grant counters.
module tb_dmem_arbiter;

   logic        clk;
   logic        resetn;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  starve_cnt;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_STARVE(4)) dut (
      .clk(clk), .resetn(resetn),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .starve_cnt(starve_cnt)
`ifdef DMEM_ARB_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          due;
   } cmd_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } rd_t;

   cmd_t        cmd_q[$];
   rd_t         rd0_q[$];
   rd_t         rd1_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [15:0] exp_cnt0 = 0;
   logic [15:0] exp_cnt1 = 0;
   logic [31:0] ram [0:255];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Synchronous write-first RAM model with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata          <= mem_wdata;
         end else begin
            mem_rdata <= ram[mem_addr[7:0]];
         end
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle of traffic: drive after the edge, check grants mid-cycle, and queue what the winner should produce.
   task automatic apply_stimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                                 input logic eg0, input logic eg1, input logic [3:0] es, input logic [31:0] erd);
      cmd_t c;
      rd_t  r;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
      check_output("gnt0", gnt0, eg0);
      check_output("gnt1", gnt1, eg1);
      check_output("starve_cnt", starve_cnt, es);
      if (eg0 || eg1) begin
         c.we    = eg1 ? w1 : w0;
         c.addr  = eg1 ? a1 : a0;
         c.wdata = eg1 ? d1 : d0;
         c.due   = cyc + 1;
         cmd_q.push_back(c);
         if (!c.we) begin
            r.data = erd;
            r.due  = cyc + 2;
            if (eg1) rd1_q.push_back(r);
            else     rd0_q.push_back(r);
         end
         if (eg0 && exp_cnt0 != 16'hFFFF) exp_cnt0++;
         if (eg1 && exp_cnt1 != 16'hFFFF) exp_cnt1++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
      end
   endtask

   // Monitor: every command and read return must match the head of its queue at the due cycle.
   cmd_t mc;
   rd_t  mr;
   always @(negedge clk) begin
      if (mem_en) begin
         if (cmd_q.size() == 0) begin
            check_output("mem_en_unexpected", mem_en, 0);
         end else begin
            mc = cmd_q.pop_front();
            check_output("cmd_cycle", cyc, mc.due);
            check_output("mem_we", mem_we, mc.we);
            check_output("mem_addr", mem_addr, mc.addr);
            check_output("mem_wdata", mem_wdata, mc.wdata);
         end
      end else begin
         check_output("mem_we_idle", mem_we, 0);
         if (cmd_q.size() > 0 && cmd_q[0].due <= cyc) begin
            check_output("mem_en_missing", mem_en, 1);
            void'(cmd_q.pop_front());
         end
      end
      if (rvalid0) begin
         if (rd0_q.size() == 0) begin
            check_output("rvalid0_unexpected", rvalid0, 0);
         end else begin
            mr = rd0_q.pop_front();
            check_output("rvalid0_cycle", cyc, mr.due);
            check_output("rdata0", rdata0, mr.data);
         end
      end else begin
         check_output("rdata0_idle", rdata0, 0);
         if (rd0_q.size() > 0 && rd0_q[0].due <= cyc) begin
            check_output("rvalid0_missing", rvalid0, 1);
            void'(rd0_q.pop_front());
         end
      end
      if (rvalid1) begin
         if (rd1_q.size() == 0) begin
            check_output("rvalid1_unexpected", rvalid1, 0);
         end else begin
            mr = rd1_q.pop_front();
            check_output("rvalid1_cycle", cyc, mr.due);
            check_output("rdata1", rdata1, mr.data);
         end
      end else begin
         check_output("rdata1_idle", rdata1, 0);
         if (rd1_q.size() > 0 && rd1_q[0].due <= cyc) begin
            check_output("rvalid1_missing", rvalid1, 1);
            void'(rd1_q.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      ram[8'h10] = 32'h0000CAFE;
      ram[8'h30] = 32'h00003333;
      ram[8'h40] = 32'h00004444;
      mem_rdata = 32'h0;
      resetn = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 32'h10; addr1 = 32'h40; wdata0 = 32'h0; wdata1 = 32'h0;

      // Reset state, with requests asserted to show grants stay low.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_gnt0", gnt0, 0);
      check_output("rst_gnt1", gnt1, 0);
      check_output("rst_mem_en", mem_en, 0);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_mem_wdata", mem_wdata, 0);
      check_output("rst_starve", starve_cnt, 0);
      check_output("rst_rvalid0", rvalid0, 0);
      check_output("rst_rvalid1", rvalid1, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(2);

      // Port-0 read of 0x10 returns 0xCAFE two cycles later.
      apply_stimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 4'd0, 32'h0000CAFE);
      idle(3);

      // Port-1 write with port 0 idle.
      apply_stimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'h5A5A, 0, 1, 4'd0, 0);
      idle(3);

      // Starvation: four port-0 grants, then port 1, then port 0 again.
      apply_stimulus(1, 0, 32'h30, 0, 1, 0, 32'h40, 0, 1, 0, 4'd0, 32'h3333);
      apply_stimulus(1, 0, 32'h30, 0, 1, 0, 32'h40, 0, 1, 0, 4'd1, 32'h3333);
      apply_stimulus(1, 0, 32'h30, 0, 1, 0, 32'h40, 0, 1, 0, 4'd2, 32'h3333);
      apply_stimulus(1, 0, 32'h30, 0, 1, 0, 32'h40, 0, 1, 0, 4'd3, 32'h3333);
      apply_stimulus(1, 0, 32'h30, 0, 1, 0, 32'h40, 0, 0, 1, 4'd4, 32'h4444);
      apply_stimulus(1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 0, 4'd0, 32'h3333);
      idle(3);

      // Port 1 withdraws its request before a grant, so its starvation count clears.
      apply_stimulus(1, 1, 32'h70, 32'h7, 1, 0, 32'h40, 0, 1, 0, 4'd0, 0);
      apply_stimulus(1, 1, 32'h70, 32'h7, 1, 0, 32'h40, 0, 1, 0, 4'd1, 0);
      apply_stimulus(1, 1, 32'h70, 32'h7, 0, 0, 0, 0, 1, 0, 4'd2, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
      idle(2);

      // Alternating back-to-back reads: port 0, port 1, port 0.
      apply_stimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 4'd0, 32'h0000CAFE);
      apply_stimulus(0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 1, 4'd0, 32'h4444);
      apply_stimulus(1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 0, 4'd0, 32'h3333);
      idle(3);

      // Read-after-write on consecutive cycles relies on the RAM alone.
      apply_stimulus(0, 0, 0, 0, 1, 1, 32'h50, 32'h1234, 0, 1, 4'd0, 0);
      apply_stimulus(1, 0, 32'h50, 0, 0, 0, 0, 0, 1, 0, 4'd0, 32'h1234);
      idle(3);

      // Reset pulse one cycle after a granted read cancels the command and its rvalid.
      apply_stimulus(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, 1, 0, 4'd0, 32'h0000CAFE);
      resetn = 1'b0;
      req1 = 1'b0;
      cmd_q.delete();
      rd0_q.delete();
      rd1_q.delete();
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      @(negedge clk);
      check_output("prst_mem_en", mem_en, 0);
      check_output("prst_starve", starve_cnt, 0);
      check_output("prst_gnt0", gnt0, 0);
      check_output("prst_rvalid0", rvalid0, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      req0 = 1'b0;
      idle(4);

`ifdef DMEM_ARB_STATS_EN
      apply_stimulus(0, 0, 0, 0, 1, 1, 32'h60, 32'h1, 0, 1, 4'd0, 0);
      for (int i = 0; i < 70000; i++) begin
         apply_stimulus(1, 1, 32'h60, i, 0, 0, 0, 0, 1, 0, 4'd0, 0);
      end
      idle(2);
      check_output("gnt_cnt0_sat", gnt_cnt0, 16'hFFFF);
      check_output("gnt_cnt0_model", gnt_cnt0, exp_cnt0);
      check_output("gnt_cnt1", gnt_cnt1, exp_cnt1);
`endif

      idle(3);
      check_output("cmd_q_drained", cmd_q.size(), 0);
      check_output("rd0_q_drained", rd0_q.size(), 0);
      check_output("rd1_q_drained", rd1_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
